// File: rtl/reg_file_mp.sv
// Multi-port register file: registered reads, hardwired zero, conflict flag, clear engine.
// Define REG_FILE_BYPASS_EN for write-first reads; default is read-first.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  output logic                         ready,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic                         wr_conflict
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0]        regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]        regs_d [DEPTH];
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                         wr_conflict_q, wr_conflict_d;
  logic [NUM_WR-1:0]            wr_ok;
  logic [ADDR_WIDTH-1:0]        ra;
  logic [DATA_WIDTH-1:0]        rv;

  // Writes to the zero register never reach the array or the conflict check
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_ok[p] = wr_en[p] &&
        !(ZERO_REG != 0 && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == '0);
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    regs_d        = regs_q;
    rd_data_d     = '0;
    wr_conflict_d = 1'b0;
    ra            = '0;
    rv            = '0;
    case (state_q)
      ST_CLEAR: begin
        regs_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = ST_READY;
      end
      ST_READY: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_ok[p])
            regs_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] =
              wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int p = 0; p < NUM_WR; p++) begin
          for (int q = p + 1; q < NUM_WR; q++) begin
            if (wr_ok[p] && wr_ok[q] &&
                wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] ==
                wr_addr[q*ADDR_WIDTH +: ADDR_WIDTH])
              wr_conflict_d = 1'b1;
          end
        end
        for (int r = 0; r < NUM_RD; r++) begin
          ra = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
          rv = regs_q[ra];
`ifdef REG_FILE_BYPASS_EN
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ra)
              rv = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
`else
          rv = regs_q[ra];
`endif
          if (ZERO_REG != 0 && ra == '0) rv = '0;
          rd_data_d[r*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      rd_data_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      rd_data_q     <= rd_data_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Array has no reset; it is zeroed by the clear engine instead
  always_ff @(posedge clk) begin
    if (rst_n) regs_q <= regs_d;
  end

  assign ready       = (state_q == ST_READY);
  assign rd_data     = rd_data_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp (default parameters, 2 read / 2 write ports).
// Honours REG_FILE_BYPASS_EN for same-cycle read/write expectations.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        ready;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        wr_conflict;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [32];

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(
    input logic [1:0]  we,
    input logic [4:0]  wa0, input logic [31:0] wd0,
    input logic [4:0]  wa1, input logic [31:0] wd1,
    input logic [4:0]  ra0, input logic [4:0] ra1,
    input bit chk, input bit in_clr, input string tag
  );
    logic [31:0] nxt [32];
    logic [4:0]  a;
    exp_t        e;
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
    nxt = mdl;
    if (!in_clr) begin
      if (we[0] && wa0 != 0) nxt[wa0] = wd0;
      if (we[1] && wa1 != 0) nxt[wa1] = wd1;
    end
    if (chk) begin
      for (int r = 0; r < 2; r++) begin
        a = (r == 0) ? ra0 : ra1;
        e.port = r;
        e.tag  = tag;
`ifdef REG_FILE_BYPASS_EN
        e.exp = nxt[a];
`else
        e.exp = mdl[a];
`endif
        if (in_clr || a == 0) e.exp = '0;
        sbq.push_back(e);
      end
    end
    tick();
    mdl   = nxt;
    wr_en = '0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      if (rd_data[e.port*32 +: 32] !== e.exp) begin
        n_bad++;
        $display("FAIL %s port%0d: got %h expected %h",
                 e.tag, e.port, rd_data[e.port*32 +: 32], e.exp);
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      step(2'b01, 5'd2, 32'h55, 5'd0, 32'h0, 5'd20, 5'd21, 1'b1, 1'b1, tag);
      cnt++;
    end
    n_cmp++;
    if (cnt != 32) begin
      n_bad++;
      $display("FAIL %s_cycles: got %0d expected 32", tag, cnt);
    end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp += 3;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got %b expected 0", ready);
    end
    if (rd_data !== 64'h0) begin
      n_bad++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
    end
    if (wr_conflict !== 1'b0) begin
      n_bad++; $display("FAIL reset_conflict: got %b expected 0", wr_conflict);
    end
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_cmp++;
    if (cnt != 32) begin
      n_bad++; $display("FAIL reset_clear_cycles: got %0d expected 32", cnt);
    end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  task automatic test_write_read();
    step(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, "wr3");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0, "rd3");
  endtask

  task automatic test_conflict();
    step(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd0, 5'd0, 1'b0, 1'b0, "wr7");
    n_cmp++;
    if (wr_conflict !== 1'b1) begin
      n_bad++; $display("FAIL conflict_set: got %b expected 1", wr_conflict);
    end
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 1'b0, "rd7");
    n_cmp++;
    if (wr_conflict !== 1'b0) begin
      n_bad++; $display("FAIL conflict_pulse: got %b expected 0", wr_conflict);
    end
    step(2'b11, 5'd8, 32'h88, 5'd9, 32'h99, 5'd8, 5'd9, 1'b1, 1'b0, "wr89");
    n_cmp++;
    if (wr_conflict !== 1'b0) begin
      n_bad++; $display("FAIL conflict_distinct: got %b expected 0", wr_conflict);
    end
  endtask

  task automatic test_zero_reg();
    step(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 1'b0, "zero_wr");
    n_cmp++;
    if (wr_conflict !== 1'b0) begin
      n_bad++; $display("FAIL zero_conflict: got %b expected 0", wr_conflict);
    end
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b1, 1'b0, "zero_rd");
  endtask

  task automatic test_bypass();
    step(2'b01, 5'd5, 32'h01, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, "wr5_old");
    step(2'b01, 5'd5, 32'hA5, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 1'b0, "rw5_same");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b1, 1'b0, "rd5_new");
    step(2'b11, 5'd6, 32'h66, 5'd6, 32'h77, 5'd6, 5'd7, 1'b1, 1'b0, "rw6_win");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b1, 1'b0, "rd6");
  endtask

  task automatic test_back_to_back();
    logic [4:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 5'(12 + i);
      step(2'b01, a, $urandom, 5'd0, 32'h0, a - 5'd1, a, 1'b1, 1'b0, "b2b");
    end
  endtask

  task automatic test_clear();
    logic [4:0] a;
    for (int i = 1; i < 32; i += 2) begin
      a = 5'(i);
      step(2'b11, a, $urandom, a + 5'd1, $urandom, 5'd0, 5'd0, 1'b0, 1'b0, "fill");
    end
    clear = 1'b1;
    step(2'b01, 5'd10, 32'hCAFE, 5'd0, 32'h0, 5'd20, 5'd10, 1'b1, 1'b0, "clr_cycle");
    clear = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL clear_ready: got %b expected 0", ready);
    end
    for (int i = 0; i < 9; i++)
      step(2'b01, 5'd2, 32'h55, 5'd0, 32'h0, 5'd20, 5'd21, 1'b1, 1'b1, "in_clear");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready("clear_restart");
    for (int i = 0; i < 32; i += 2) begin
      a = 5'(i);
      step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, a, a + 5'd1, 1'b1, 1'b0, "post_clear");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
